piso_serial_tx: RTL and testbench

- Parallel-in/serial-out transmitter for the storage-element track.
- Takes one DATA_W-bit word per valid/ready handshake and shifts it out on a single line as a frame: start bit, data bits LSB first, stop bit.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Serves as the sending end for the serial-in capture blocks: the line idles high and the framing is fixed.

---
 rtl/piso_tx_pkg.sv | 19 +
 rtl/piso_serial_tx_bit_timer.sv | 34 +++
 rtl/piso_serial_tx.sv | 118 +++++++++++
 tb/tb_piso_serial_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and line levels for the parallel-in/serial-out transmitter.
//   tx_state_t : frame sequencing states
//   LINE_IDLE  : level driven while no frame is in progress
//   START_BIT  : level of the framing start bit
//   STOP_BIT   : level of the framing stop bit
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of every bit period.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_clear : hold the count at zero (used while the line is idle)
//   o_tick  : high on the final cycle of the current bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (i_clear || tick_cnt == LAST_TICK) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // With CLKS_PER_BIT=1 the count is stuck at 0 and every cycle ticks.
    assign o_tick = (tick_cnt == LAST_TICK);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter. Accepts one word per valid/ready
// handshake and sends it as start bit, DATA_W data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT cycles. The line idles high.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_data  : parallel word, sampled only on an accepted handshake
//   i_valid : sender has a word on i_data
//   o_ready : a word can be accepted this cycle
//   o_tx    : serial line
//   o_busy  : frame in progress
//   o_done  : pulse on the final cycle of the stop bit
//
// state | meaning
// IDLE  | line high, waiting for i_valid
// START | driving the start bit
// DATA  | driving shift_reg[0], shifting at each bit boundary
// STOP  | driving the stop bit, o_done on its last cycle
module piso_serial_tx
    import piso_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [BW-1:0]     bit_cnt;
    logic              tick;

    // The timer sits at zero while idle so the start bit gets a full period
    // beginning on the cycle after acceptance.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clear(state == IDLE),
        .o_tick (tick)
    );

    assign shift_next = shift_reg >> 1;

    // o_tx is registered one cycle ahead: each transition loads the level the
    // line must carry in the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            o_tx      <= LINE_IDLE;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift_reg <= i_data;
                        state     <= START;
                        o_tx      <= START_BIT;
                        o_ready   <= 1'b0;
                        o_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        o_tx    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            o_tx  <= STOP_BIT;
                        end else begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + BW'(1);
                            o_tx      <= shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        o_tx    <= LINE_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_tx    <= LINE_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Decoded purely from registered state and the timer count, so it does
    // not depend on any input.
    assign o_done = (state == STOP) && tick;

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, tx_a, busy_a, done_a;

    logic [7:0] data_b;
    logic       valid_b;
    logic       ready_b, tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_data (data_a),
        .i_valid(valid_a),
        .o_ready(ready_a),
        .o_tx   (tx_a),
        .o_busy (busy_a),
        .o_done (done_a)
    );

    piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_data (data_b),
        .i_valid(valid_b),
        .o_ready(ready_b),
        .o_tx   (tx_b),
        .o_busy (busy_b),
        .o_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: frame bit j (0=start, 1..8=data LSB first, 9=stop).
    function automatic logic frame_bit(input logic [7:0] w, input int j);
        logic [9:0] f;
        f = {1'b1, w, 1'b0};
        return f[j];
    endfunction

    // Idle expectations on DUT A, sampled at the current negedge.
    task automatic check_idle_a(input string name);
        total++;
        if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
            bad++;
            $display("FAIL %s idle: tx/ready/busy/done=%b%b%b%b expected 1100",
                     name, tx_a, ready_a, busy_a, done_a);
        end
    endtask

    // Sends one word on DUT A (CLKS_PER_BIT=4) and checks all 40 frame cycles
    // plus the following idle cycle. Optional: scramble i_data every cycle,
    // or pulse i_valid with 8'hFF at cycle 10.
    task automatic send_frame_a(input logic [7:0] word, input string name,
                                input bit scramble, input bit inject);
        int errs;
        logic exp_tx;
        @(negedge clk);
        data_a  = word;
        valid_a = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_tx = frame_bit(word, k / 4);
            total++;
            if (tx_a !== exp_tx || ready_a !== 1'b0 || busy_a !== 1'b1 ||
                done_a !== (k == 39)) begin
                bad++;
                errs++;
                if (errs < 4)
                    $display("FAIL %s cycle %0d: tx=%b ready=%b busy=%b done=%b expected tx=%b ready=0 busy=1 done=%b",
                             name, k + 1, tx_a, ready_a, busy_a, done_a, exp_tx, (k == 39));
            end
            if (scramble) data_a = 8'($urandom);
            if (inject && k == 9) begin
                data_a  = 8'hFF;
                valid_a = 1'b1;
            end
            if (inject && k == 10) valid_a = 1'b0;
        end
        @(negedge clk);
        check_idle_a({name, " after"});
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        data_a  = 8'hA5;
        data_b  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_a("reset_a");
            total++;
            if ({tx_b, ready_b, busy_b, done_b} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_b: tx/ready/busy/done=%b%b%b%b expected 1100",
                         tx_b, ready_b, busy_b, done_b);
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check_idle_a("post_reset");
    endtask

    task automatic test_single_frame;
        send_frame_a(8'hA5, "frame_a5", 1'b0, 1'b0);
    endtask

    task automatic test_busy_reject;
        send_frame_a(8'h3C, "busy_reject", 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_idle_a("no_second_frame");
        end
    endtask

    task automatic test_data_stability;
        send_frame_a(8'hC3, "stable_c3", 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] w;
        for (int n = 0; n < 5; n++) begin
            w = 8'($urandom);
            send_frame_a(w, "random", 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back;
        logic [0:21] exp_tx;
        logic [0:21] exp_rdy;
        logic [0:21] exp_done;
        int dones;
        // Frame 1 at cycles 0..9, one idle cycle at 10, frame 2 at 11..20.
        for (int k = 0; k < 22; k++) begin
            if (k < 10) begin
                exp_tx[k] = frame_bit(8'h01, k);
                exp_rdy[k] = 1'b0;
                exp_done[k] = (k == 9);
            end else if (k >= 11 && k < 21) begin
                exp_tx[k] = frame_bit(8'h80, k - 11);
                exp_rdy[k] = 1'b0;
                exp_done[k] = (k == 20);
            end else begin
                exp_tx[k] = 1'b1;
                exp_rdy[k] = 1'b1;
                exp_done[k] = 1'b0;
            end
        end
        dones = 0;
        @(negedge clk);
        data_b  = 8'h01;
        valid_b = 1'b1;
        @(posedge clk);
        #1 data_b = 8'h80;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (done_b === 1'b1) dones++;
            total++;
            if (tx_b !== exp_tx[k] || ready_b !== exp_rdy[k] ||
                busy_b !== ~exp_rdy[k] || done_b !== exp_done[k]) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: tx=%b ready=%b busy=%b done=%b expected tx=%b ready=%b busy=%b done=%b",
                         k + 1, tx_b, ready_b, busy_b, done_b,
                         exp_tx[k], exp_rdy[k], ~exp_rdy[k], exp_done[k]);
            end
            if (k == 11) valid_b = 1'b0;
        end
        total++;
        if (dones != 2) begin
            bad++;
            $display("FAIL back_to_back done count: got %0d expected 2", dones);
        end
    endtask

    task automatic test_reset_mid_frame;
        // 8'h37 has data bit 3 = 0, so the line is low when reset hits.
        @(negedge clk);
        data_a  = 8'h37;
        valid_a = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        // Data bit 3 occupies cycles 17..20; stop partway through.
        for (int k = 0; k < 18; k++) @(negedge clk);
        total++;
        if (tx_a !== 1'b0) begin
            bad++;
            $display("FAIL mid_frame pre-reset: tx=%b expected 0", tx_a);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
            bad++;
            $display("FAIL async_reset: tx/ready/busy/done=%b%b%b%b expected 1100",
                     tx_a, ready_a, busy_a, done_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_a("after_mid_reset");
        end
        send_frame_a(8'h5A, "frame_5a", 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        test_reset();
        test_single_frame();
        test_busy_reject();
        test_data_stability();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
